// File: rtl/nrzi_pkg.sv
// Shared types and limits for the USB NRZI receive path.
package nrzi_pkg;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0,
    LS_SE1
  } lineState_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP,
    ST_ERR
  } rxState_t;

  localparam logic [2:0] STUFF_LIMIT    = 3'd6;
  localparam logic [2:0] SYNC_MIN_ZEROS = 3'd5;
  localparam logic [2:0] EOP_MAX_SE0    = 3'd3;

endpackage

// File: rtl/usb_line_sync.sv
// Two-flop synchronizer for the raw bus pair followed by J/K/SE0/SE1 decode.
module usb_line_sync
  import nrzi_pkg::*;
#(
  parameter bit LOW_SPEED = 1'b1
) (
  input  logic       useClk,
  input  logic       reset,
  input  logic       dPlus,
  input  logic       dMinus,
  output lineState_t lineState
);

  // {dPlus, dMinus} pattern that means J for the selected bus speed
  localparam logic [1:0] J_LINES = LOW_SPEED ? 2'b01 : 2'b10;

  logic [1:0] syncQ1;
  logic [1:0] syncQ2;

  always_ff @(posedge useClk or posedge reset) begin
    if (reset) begin
      syncQ1 <= J_LINES;
      syncQ2 <= J_LINES;
    end else begin
      syncQ1 <= {dPlus, dMinus};
      syncQ2 <= syncQ1;
    end
  end

  always_comb begin
    if (syncQ2 == 2'b00)         lineState = LS_SE0;
    else if (syncQ2 == 2'b11)    lineState = LS_SE1;
    else if (syncQ2 == J_LINES)  lineState = LS_J;
    else                         lineState = LS_K;
  end

endmodule

// File: rtl/nrzi_rx_decoder.sv
// USB receive decoder: SYNC detection, NRZI decode, bit-stuff removal,
// LSB-first byte assembly and EOP/error reporting, advanced by checkData.
module nrzi_rx_decoder
  import nrzi_pkg::*;
#(
  parameter bit LOW_SPEED = 1'b1
) (
  input  logic       useClk,
  input  logic       reset,
  input  logic       checkData,
  input  logic       dPlus,
  input  logic       dMinus,
  output logic [7:0] rxByte,
  output logic       rxByteValid,
  output logic       rxActive,
  output logic       rxEop,
  output logic       rxError,
  output rxState_t   dbgState
);

  lineState_t lineState;
  rxState_t   state, stateNext;
  lineState_t prevState, prevNext;
  logic [2:0] zeroCount, zeroNext;
  logic [2:0] bitCount, bitNext;
  logic [2:0] onesCount, onesNext;
  logic [2:0] se0Count, se0Next;
  logic [7:0] shiftReg, shiftNext;
  logic [7:0] byteNext;
  logic       validNext, activeNext, eopNext, errorNext;
  logic       isJk, rxBit;

  usb_line_sync #(.LOW_SPEED(LOW_SPEED)) uLineSync (
    .useClk   (useClk),
    .reset    (reset),
    .dPlus    (dPlus),
    .dMinus   (dMinus),
    .lineState(lineState)
  );

  assign dbgState = state;

  always_ff @(posedge useClk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      prevState   <= LS_J;
      zeroCount   <= '0;
      bitCount    <= '0;
      onesCount   <= '0;
      se0Count    <= '0;
      shiftReg    <= '0;
      rxByte      <= '0;
      rxByteValid <= 1'b0;
      rxActive    <= 1'b0;
      rxEop       <= 1'b0;
      rxError     <= 1'b0;
    end else if (checkData) begin
      state       <= stateNext;
      prevState   <= prevNext;
      zeroCount   <= zeroNext;
      bitCount    <= bitNext;
      onesCount   <= onesNext;
      se0Count    <= se0Next;
      shiftReg    <= shiftNext;
      rxByte      <= byteNext;
      rxByteValid <= validNext;
      rxActive    <= activeNext;
      rxEop       <= eopNext;
      rxError     <= errorNext;
    end else begin
      rxByteValid <= 1'b0;
      rxEop       <= 1'b0;
      rxError     <= 1'b0;
    end
  end

  always_comb begin
    stateNext  = state;
    prevNext   = prevState;
    zeroNext   = zeroCount;
    bitNext    = bitCount;
    onesNext   = onesCount;
    se0Next    = se0Count;
    shiftNext  = shiftReg;
    byteNext   = rxByte;
    validNext  = 1'b0;
    activeNext = rxActive;
    eopNext    = 1'b0;
    errorNext  = 1'b0;

    isJk  = (lineState == LS_J) || (lineState == LS_K);
    // NRZI: no transition between consecutive J/K samples is a 1
    rxBit = (lineState == prevState);
    if (isJk) prevNext = lineState;

    case (state)
      ST_IDLE: begin
        if (lineState == LS_K) begin
          stateNext = ST_SYNC;
          zeroNext  = '0;
        end
      end
      ST_SYNC: begin
        if (!isJk) begin
          stateNext = ST_IDLE;
        end else if (!rxBit) begin
          if (zeroCount != 3'd7) zeroNext = zeroCount + 3'd1;
        end else if (zeroCount >= SYNC_MIN_ZEROS) begin
          stateNext  = ST_DATA;
          activeNext = 1'b1;
          bitNext    = '0;
          onesNext   = '0;
        end else begin
          stateNext = ST_IDLE;
        end
      end
      ST_DATA: begin
        case (lineState)
          LS_SE0: begin
            stateNext = ST_EOP;
            se0Next   = 3'd1;
          end
          LS_SE1: begin
            stateNext  = ST_ERR;
            errorNext  = 1'b1;
            activeNext = 1'b0;
          end
          default: begin
            // After six 1s the next bit is a stuffed 0; a 1 there is a violation
            if (onesCount == STUFF_LIMIT) begin
              if (rxBit) begin
                stateNext  = ST_ERR;
                errorNext  = 1'b1;
                activeNext = 1'b0;
              end else begin
                onesNext = '0;
              end
            end else begin
              shiftNext = {rxBit, shiftReg[7:1]};
              bitNext   = bitCount + 3'd1;
              onesNext  = rxBit ? onesCount + 3'd1 : 3'd0;
              if (bitCount == 3'd7) begin
                byteNext  = {rxBit, shiftReg[7:1]};
                validNext = 1'b1;
              end
            end
          end
        endcase
      end
      ST_EOP: begin
        case (lineState)
          LS_SE0: begin
            se0Next = se0Count + 3'd1;
            if (se0Count == EOP_MAX_SE0) begin
              stateNext  = ST_ERR;
              errorNext  = 1'b1;
              activeNext = 1'b0;
            end
          end
          LS_J: begin
            stateNext  = ST_IDLE;
            eopNext    = 1'b1;
            activeNext = 1'b0;
            errorNext  = (bitCount != 3'd0);
          end
          default: begin
            stateNext  = ST_ERR;
            errorNext  = 1'b1;
            activeNext = 1'b0;
          end
        endcase
      end
      ST_ERR: begin
        if (lineState == LS_J) stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: doc/nrzi_rx_decoder.md
NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

Interface
REQ-001 SHALL have parameter LOW_SPEED, default 1, selecting J = (dPlus=0, dMinus=1) and K = (1,0); when 0, J = (1,0) and K = (0,1).
REQ-002 SHALL have port useClk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port checkData  input  1  one-cycle bit-period strobe; line sampled only when high.
REQ-005 SHALL have ports dPlus and dMinus  input  1 each  raw bus lines, asynchronous to useClk.
REQ-006 SHALL have port rxByte  output  8  last completed byte, LSB received first.
REQ-007 SHALL have port rxByteValid  output  1  one-cycle pulse when rxByte updates.
REQ-008 SHALL have port rxActive  output  1  high from SYNC completion to EOP or error.
REQ-009 SHALL have port rxEop  output  1  one-cycle pulse on valid end of packet.
REQ-010 SHALL have port rxError  output  1  one-cycle pulse on stuff, SE1, SE0-length or partial-byte error.

Function
REQ-011 SHALL pass dPlus/dMinus through a 2-FF synchronizer clocked every useClk cycle, then decode line state J/K/SE0/SE1.
REQ-012 SHALL advance state, counters and outputs only on edges where checkData=1; all outputs are registered, and pulse outputs clear on the next edge.
REQ-013 SHALL decode a J/K sample as bit 1 if equal to the previous J/K sample, else 0; prevState updates on every J/K sample.
REQ-014 SHALL implement FSM states IDLE, SYNC, DATA, EOP, ERR.
REQ-015 IDLE: a K sample goes to SYNC with zeroCount=0; other samples stay in IDLE.
REQ-016 SYNC: each decoded 0 increments zeroCount, saturating at 7.
REQ-017 SYNC: a decoded 1 with zeroCount>=5 goes to DATA, sets rxActive=1, and clears bitCount and onesCount.
REQ-018 SYNC: a decoded 1 with zeroCount<5, or an SE0, returns to IDLE without any pulse.
REQ-019 DATA: non-stuffed bits shift LSB-first into a shift register; bitCount wraps 7->0.
REQ-020 DATA: on the 8th bit, rxByte loads the assembled byte and rxByteValid pulses.
REQ-021 DATA: onesCount increments on decoded 1 and clears on decoded 0; at onesCount=6 the next sample is a stuffed bit.
REQ-022 DATA: a stuffed decoded 0 is dropped (no shift) and clears onesCount; a stuffed decoded 1 pulses rxError, goes to ERR and clears rxActive.
REQ-023 DATA: SE0 goes to EOP with se0Count=1.
REQ-024 DATA or EOP: SE1 pulses rxError, goes to ERR and clears rxActive.
REQ-025 EOP: SE0 increments se0Count.
REQ-026 EOP: se0Count reaching 4 pulses rxError and goes to ERR.
REQ-027 EOP: J with se0Count in 1..3 pulses rxEop, clears rxActive, sets prevState=J and goes to IDLE.
REQ-028 EOP: K pulses rxError and goes to ERR.
REQ-029 SHALL pulse rxError in the same cycle as rxEop if bitCount!=0 at the EOP J sample; rxByte is not updated.
REQ-030 ERR: stay until a J sample, then go to IDLE with prevState=J; no rxByteValid while in ERR.
REQ-031 A byte completion and an error SHALL never both occur on one sample; the error takes precedence and rxByteValid stays low.

Reset
REQ-032 While reset=1, SHALL asynchronously force state=IDLE, prevState=J, synchronizer flops to J, and all counters to 0.
REQ-033 While reset=1, SHALL force rxByte=0x00 and rxByteValid, rxActive, rxEop, rxError all to 0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; after release, decoding starts only at the next K in IDLE.

Structure
REQ-035 Package nrzi_pkg SHALL hold the line-state enum (J, K, SE0, SE1), the FSM state typedef, STUFF_LIMIT=6, SYNC_MIN_ZEROS=5 and EOP_MAX_SE0=3.
REQ-036 Sub-module usb_line_sync SHALL contain the 2-FF synchronizer and the line-state decode; the FSM, stuffing logic and shifter are inline.

Verification
REQ-037 SYNC KJKJKJKK, byte 0xA5, SE0 SE0 J -> one rxByteValid with rxByte=0xA5, then rxEop, rxActive 1->0, rxError never high.
REQ-038 Bytes 0xFF,0x3F with correctly inserted stuffed zeros -> rxByteValid twice (0xFF then 0x3F), no rxError.
REQ-039 Six decoded 1s followed by a seventh 1 (no transition) -> rxError pulse, rxActive=0, no rxByteValid until J then new SYNC.
REQ-040 EOP after 3 data bits of a byte -> rxEop and rxError in the same cycle, rxByte unchanged.
REQ-041 Reset pulse mid-byte, then a clean packet with byte 0x5A -> outputs 0 during reset, then rxByte=0x5A valid.
REQ-042 checkData held low for 10 cycles mid-packet -> no state change; SE1 sample in DATA -> rxError pulse.
